pdm_pingpong_buf: RTL and testbench

Parametrised ping-pong (double) capture buffer for the PDM sample path. A streaming writer fills one bank with auto-incrementing addresses while the reader randomly accesses the other, completed bank. Banks swap on a fill/release handshake, and dropped samples are counted. It replaces the single-bank, single-port data buffer in the capture chain between the PDM decimator and the PS/readout logic.

---
 rtl/pdm_pingpong_buf_pkg.sv | 26 ++
 rtl/pdm_pingpong_buf_dbuf_bank.sv | 29 ++
 rtl/pdm_pingpong_buf.sv | 115 +++++++++++
 tb/tb_pdm_pingpong_buf.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pdm_pingpong_buf_pkg.sv
// Shared definitions for the PDM ping-pong capture buffer: default sizing,
// bank-state encodings and the saturating drop-counter helper.
package pdm_pingpong_buf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 24576;
  localparam int DROP_W     = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Lifecycle view of one bank, derived from its full flag and writer ownership.
  function automatic bank_state_e bank_state(input logic full, input logic is_wr_bank);
    if (full)       return BANK_FULL;
    if (is_wr_bank) return BANK_FILLING;
    return BANK_EMPTY;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
    return (&value) ? value : value + DROP_W'(1);
  endfunction

endpackage

// File: rtl/pdm_pingpong_buf_dbuf_bank.sv
// One capture bank: simple dual-port RAM, one write port and one registered
// read port with read-before-write behaviour on a same-address collision.
module pdm_pingpong_buf_dbuf_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 24576,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array and its read register carry no reset so the tools can map
  // them onto block RAM; the top level masks rd_data until the first read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pdm_pingpong_buf.sv
// Ping-pong capture buffer: the writer streams into one bank while the reader
// randomly accesses the other, completed bank; banks swap on fill/release.
module pdm_pingpong_buf
  import pdm_pingpong_buf_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] wr_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_bank_valid,
  output logic              rd_bank_sel,
  input  logic              rd_release,
  output logic [15:0]       drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_rd_sel;
  logic              r_rd_zero;

  logic [1:0]        w_full_nxt;
  logic              w_wr_accept;
  logic              w_fill_done;
  logic              w_release;
  logic              w_rd_oob;
  logic [1:0]        w_bank_we;
  logic [1:0]        w_bank_re;
  logic [DATA_W-1:0] w_bank_rdata [2];

  assign wr_ready      = ~r_full[r_wr_bank];
  assign rd_bank_valid = r_full[r_rd_bank];
  assign rd_bank_sel   = r_rd_bank;
  assign wr_count      = r_wr_ptr;
  assign drop_cnt      = r_drop_cnt;

  assign w_wr_accept = wr_valid & wr_ready;
  assign w_fill_done = w_wr_accept & (r_wr_ptr == LAST_ADDR);
  assign w_release   = rd_release & rd_bank_valid;
  assign w_rd_oob    = 32'(rd_addr) >= 32'(DEPTH);

  // A fill and a release in the same cycle always touch different banks: the
  // writer only fills a non-full bank and the reader only releases a full one.
  // NOTE: combinational blocks use blocking assignments, defaults first, so
  // every path assigns every output and no latch is inferred.
  always_comb begin
    w_full_nxt = r_full;
    if (w_fill_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release)   w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_comb begin
    w_bank_we = '0;
    w_bank_re = '0;
    if (w_wr_accept)          w_bank_we[r_wr_bank] = 1'b1;
    if (rd_en && !w_rd_oob)   w_bank_re[r_rd_bank] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_ptr   <= '0;
      r_drop_cnt <= '0;
      r_rd_sel   <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_accept) r_wr_ptr <= w_fill_done ? '0 : r_wr_ptr + ADDR_W'(1);
      if (w_fill_done) r_wr_bank <= ~r_wr_bank;
      if (w_release)   r_rd_bank <= ~r_rd_bank;
      if (wr_valid && !wr_ready) r_drop_cnt <= sat_inc(r_drop_cnt);
      // Output mux select is captured with the read so it lines up with RAM latency.
      if (rd_en) begin
        r_rd_sel  <= r_rd_bank;
        r_rd_zero <= w_rd_oob;
      end
    end
  end

  assign rd_data = r_rd_zero ? '0 : w_bank_rdata[r_rd_sel];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    pdm_pingpong_buf_dbuf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_bank_we[g]),
      .i_waddr (r_wr_ptr),
      .i_wdata (wr_data),
      .i_re    (w_bank_re[g]),
      .i_raddr (rd_addr),
      .o_rdata (w_bank_rdata[g])
    );
  end

endmodule

// File: tb/tb_pdm_pingpong_buf.sv
// Directed, table-driven bench for pdm_pingpong_buf at DEPTH=4, DATA_W=32.
module tb_pdm_pingpong_buf;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_bank_valid;
  logic              rd_bank_sel;
  logic              rd_release;
  logic [15:0]       drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pdm_pingpong_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .wr_count      (wr_count),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_bank_valid (rd_bank_valid),
    .rd_bank_sel   (rd_bank_sel),
    .rd_release    (rd_release),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              wv;
    logic [DATA_W-1:0] wd;
    logic              re;
    logic [ADDR_W-1:0] ra;
    logic              rel;
    logic              rdy;
    logic [ADDR_W-1:0] cnt;
    logic              rbv;
    logic              sel;
    logic [DATA_W-1:0] rdata;
    logic [15:0]       drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic wv, input logic [31:0] wd,
                              input logic re, input logic [1:0] ra, input logic rel,
                              input logic rdy, input logic [1:0] cnt, input logic rbv,
                              input logic sel, input logic [31:0] rdata, input logic [15:0] drop);
    vec_t v;
    v.rst = r; v.wv = wv; v.wd = wd; v.re = re; v.ra = ra; v.rel = rel;
    v.rdy = rdy; v.cnt = cnt; v.rbv = rbv; v.sel = sel; v.rdata = rdata; v.drop = drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector, let one rising edge pass, then compare away from the edge.
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; wr_valid = v.wv; wr_data = v.wd;
    rd_en = v.re; rd_addr = v.ra; rd_release = v.rel;
    @(posedge clk);
    #2;
    check({tag, " wr_ready"},      32'(wr_ready),      32'(v.rdy));
    check({tag, " wr_count"},      32'(wr_count),      32'(v.cnt));
    check({tag, " rd_bank_valid"}, 32'(rd_bank_valid), 32'(v.rbv));
    check({tag, " rd_bank_sel"},   32'(rd_bank_sel),   32'(v.sel));
    check({tag, " rd_data"},       rd_data,            v.rdata);
    check({tag, " drop_cnt"},      32'(drop_cnt),      32'(v.drop));
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
    @(negedge clk);

    //                    rst wv  wd     re ra rel | rdy cnt rbv sel rdata  drop
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 0,   1, 0, 0, 0, 32'h00, 0));  // 0 reset
    vecs.push_back(mk(0, 1, 32'hA0, 0, 0, 0,   1, 1, 0, 0, 32'h00, 0));
    vecs.push_back(mk(0, 1, 32'hA1, 0, 0, 0,   1, 2, 0, 0, 32'h00, 0));
    vecs.push_back(mk(0, 1, 32'hA2, 0, 0, 0,   1, 3, 0, 0, 32'h00, 0));
    vecs.push_back(mk(0, 1, 32'hA3, 0, 0, 0,   1, 0, 1, 0, 32'h00, 0));  // bank 0 full
    vecs.push_back(mk(0, 0, 32'h00, 1, 0, 0,   1, 0, 1, 0, 32'hA0, 0));
    vecs.push_back(mk(0, 0, 32'h00, 1, 1, 0,   1, 0, 1, 0, 32'hA1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 1, 2, 0,   1, 0, 1, 0, 32'hA2, 0));
    vecs.push_back(mk(0, 0, 32'h00, 1, 3, 0,   1, 0, 1, 0, 32'hA3, 0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   1, 0, 1, 0, 32'hA3, 0));  // rd_data holds
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   1, 0, 0, 1, 32'hA3, 0));  // release bank 0
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   1, 0, 0, 1, 32'hA3, 0));  // ignored release
    vecs.push_back(mk(0, 1, 32'hB0, 0, 0, 0,   1, 1, 0, 1, 32'hA3, 0));
    vecs.push_back(mk(0, 1, 32'hB1, 0, 0, 0,   1, 2, 0, 1, 32'hA3, 0));
    vecs.push_back(mk(0, 1, 32'hB2, 0, 0, 0,   1, 3, 0, 1, 32'hA3, 0));
    vecs.push_back(mk(0, 1, 32'hB3, 0, 0, 0,   1, 0, 1, 1, 32'hA3, 0));  // bank 1 full
    vecs.push_back(mk(0, 0, 32'h00, 1, 2, 0,   1, 0, 1, 1, 32'hB2, 0));
    vecs.push_back(mk(0, 1, 32'hC0, 0, 0, 0,   1, 1, 1, 1, 32'hB2, 0));
    vecs.push_back(mk(0, 1, 32'hC1, 0, 0, 0,   1, 2, 1, 1, 32'hB2, 0));
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 0,   1, 0, 0, 0, 32'h00, 0));  // reset mid-fill
    vecs.push_back(mk(0, 1, 32'hE0, 1, 0, 0,   1, 1, 0, 0, 32'hC0, 0));  // read-before-write
    vecs.push_back(mk(0, 1, 32'hE1, 1, 1, 0,   1, 2, 0, 0, 32'hC1, 0));
    vecs.push_back(mk(0, 1, 32'hE2, 0, 0, 0,   1, 3, 0, 0, 32'hC1, 0));
    vecs.push_back(mk(0, 1, 32'hE3, 0, 0, 0,   1, 0, 1, 0, 32'hC1, 0));
    vecs.push_back(mk(0, 0, 32'h00, 1, 0, 0,   1, 0, 1, 0, 32'hE0, 0));
    vecs.push_back(mk(0, 1, 32'hF0, 0, 0, 0,   1, 1, 1, 0, 32'hE0, 0));
    vecs.push_back(mk(0, 1, 32'hF1, 0, 0, 0,   1, 2, 1, 0, 32'hE0, 0));
    vecs.push_back(mk(0, 1, 32'hF2, 0, 0, 0,   1, 3, 1, 0, 32'hE0, 0));
    vecs.push_back(mk(0, 1, 32'hF3, 0, 0, 0,   0, 0, 1, 0, 32'hE0, 0));  // both full
    vecs.push_back(mk(0, 1, 32'hD0, 0, 0, 0,   0, 0, 1, 0, 32'hE0, 1));  // drops
    vecs.push_back(mk(0, 1, 32'hD1, 0, 0, 0,   0, 0, 1, 0, 32'hE0, 2));
    vecs.push_back(mk(0, 1, 32'hD2, 0, 0, 0,   0, 0, 1, 0, 32'hE0, 3));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   1, 0, 1, 1, 32'hE0, 3));  // release bank 0
    vecs.push_back(mk(0, 0, 32'h00, 1, 1, 0,   1, 0, 1, 1, 32'hF1, 3));
    vecs.push_back(mk(0, 1, 32'h10, 0, 0, 0,   1, 1, 1, 1, 32'hF1, 3));
    vecs.push_back(mk(0, 1, 32'h11, 0, 0, 0,   1, 2, 1, 1, 32'hF1, 3));
    vecs.push_back(mk(0, 1, 32'h12, 0, 0, 0,   1, 3, 1, 1, 32'hF1, 3));
    vecs.push_back(mk(0, 1, 32'h13, 0, 0, 1,   1, 0, 1, 0, 32'hF1, 3));  // fill b0 + release b1
    vecs.push_back(mk(0, 1, 32'h20, 0, 0, 0,   1, 1, 1, 0, 32'hF1, 3));
    vecs.push_back(mk(0, 1, 32'h21, 0, 0, 0,   1, 2, 1, 0, 32'hF1, 3));
    vecs.push_back(mk(0, 1, 32'h22, 0, 0, 0,   1, 3, 1, 0, 32'hF1, 3));
    vecs.push_back(mk(0, 1, 32'h23, 0, 0, 1,   1, 0, 1, 1, 32'hF1, 3));  // fill b1 + release b0
    vecs.push_back(mk(0, 1, 32'h30, 0, 0, 0,   1, 1, 1, 1, 32'hF1, 3));  // lands in bank0[0]
    vecs.push_back(mk(0, 0, 32'h00, 1, 0, 0,   1, 1, 1, 1, 32'h20, 3));
    vecs.push_back(mk(0, 0, 32'h00, 1, 3, 0,   1, 1, 1, 1, 32'h23, 3));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   1, 1, 0, 0, 32'h23, 3));  // release bank 1
    vecs.push_back(mk(0, 0, 32'h00, 1, 0, 0,   1, 1, 0, 0, 32'h30, 3));  // ungated read
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   1, 1, 0, 0, 32'h30, 3));  // ignored release

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Saturation: reset, fill both banks, then hold wr_valid high with no release.
    apply(mk(1, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0), "sat_reset");
    for (int k = 0; k < 8; k++)
      apply(mk(0, 1, 32'h100 + 32'(k), 0, 0, 0, (k < 7) ? 1'b1 : 1'b0, 2'((k + 1) % 4),
               (k >= 3) ? 1'b1 : 1'b0, 0, 32'h0, 0), $sformatf("sat_fill%0d", k));
    wr_valid = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #2;
    check("drop_cnt_65534", 32'(drop_cnt), 32'hFFFE);
    for (int i = 0; i < 70000 - 65534; i++) @(posedge clk);
    #2;
    check("drop_cnt_sat", 32'(drop_cnt), 32'hFFFF);
    check("wr_ready_sat", 32'(wr_ready), 32'h0);
    apply(mk(1, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0), "sat_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
